bsg_div_seq: RTL and testbench
==============================

# bsg_div_seq

Sequential radix-2 integer divider, the inverse companion of the combinational multiplier: computes quotient and remainder of two `width_p`-bit operands, signed or unsigned, one quotient bit per cycle. Sits behind a ready/valid input and a valid/yumi output, so it drops into execute pipelines, for example the muldiv unit of a core, where the long-latency divide is decoupled from issue.

## Interface
- `width_p`, default 32: operand, quotient and remainder width; must be ≥ 2.
- `clk_i` input 1: clock.
- `reset_i` input 1: asynchronous, active-high reset.
- `v_i` input 1: operands valid.
- `ready_o` output 1: block can accept operands.
- `dividend_i` input `width_p`: dividend.
- `divisor_i` input `width_p`: divisor.
- `signed_i` input 1: 1 means two's-complement operands; 0 means unsigned operands. Sampled with the operands.
- `v_o` output 1: result valid.
- `quotient_o` output `width_p`: quotient.
- `remainder_o` output `width_p`: remainder.
- `yumi_i` input 1: consumer takes the result. Only legal while `v_o` is 1.

## Operation
- States:
  - IDLE: `ready_o`=1.
  - CALC: shift/subtract loop.
  - DONE: `v_o`=1.
- IDLE → CALC on `v_i & ready_o` (accept).
  - On accept, register the magnitudes of both operands.
  - If `signed_i`, also register the sign of the quotient (dividend sign XOR divisor sign) and the sign of the remainder (dividend sign).
  - Clear the partial remainder and load an iteration counter with `width_p-1`.
- CALC, each cycle:
  - Form {remainder, quotient} shifted left by 1.
  - Trial-subtract the divisor magnitude from the partial remainder using a `width_p+1`-bit difference.
  - If the result is non-negative, keep the difference and set quotient LSB=1. Otherwise restore and set LSB=0.
  - Decrement the counter. When the counter is 0, go to DONE.
- On the CALC→DONE edge, `quotient_o` and `remainder_o` are loaded with the sign-corrected results:
  - If the quotient sign is 1, the quotient is negated.
  - If the remainder sign is 1, the remainder is negated.
  - Sign correction applies only when `signed_i` was 1.
- DONE → IDLE on `yumi_i`. `ready_o` is 0 in DONE, so there is no same-cycle re-accept.
- Divisor = 0 (any signedness): quotient = all ones, remainder = dividend unchanged.
- Signed overflow (most-negative ÷ -1): quotient = most-negative, remainder = 0. This falls out naturally from magnitude arithmetic and must not be special-cased into anything else.
- Results are truncating: the quotient rounds toward zero, and a nonzero remainder has the sign of the dividend.
- `quotient_o`, `remainder_o` and `signed_i`-derived state hold their values throughout DONE regardless of input activity.

## Timing
- Reset values:
  - state = IDLE
  - `v_o`=0
  - `quotient_o`=0
  - `remainder_o`=0
  - `ready_o`=0 while `reset_i`=1, and 1 in the first cycle after deassertion.
- Latency: accept in cycle t → CALC in cycles t+1..t+`width_p` → `v_o`=1 from cycle t+`width_p`+1.
- Maximum throughput is one divide per `width_p`+2 cycles, when `yumi_i` is asserted in the first DONE cycle.
- `v_o` stays high indefinitely under backpressure, with outputs stable.
- Reset asserted mid-CALC or in DONE:
  - Immediately returns the block to IDLE with `v_o`=0 and outputs cleared.
  - The in-flight operation is discarded with no completion.
- `v_i` while `ready_o`=0 is ignored, and the operands are not sampled.

## Configuration
- `BSG_DIV_SEQ_ZERO_FAST_EN` defined:
  - On accept, a divisor of 0 bypasses CALC and goes directly to DONE.
  - Result values are as specified above, with `v_o`=1 in cycle t+1.
- Undefined:
  - A divisor of 0 runs the full CALC loop.
  - `v_o` rises at t+`width_p`+1 with identical result values.
- All other behaviour is identical in both builds.

## Test plan
- `width_p`=8, unsigned 200 ÷ 7, accept at cycle t → `v_o`=1 first at t+9, `quotient_o`=0x1C (28), `remainder_o`=0x04.
- `width_p`=8, signed -7 ÷ 2 (0xF9, 0x02) → `quotient_o`=0xFD (-3), `remainder_o`=0xFF (-1). Signed 7 ÷ -2 → 0xFD, 0x01.
- `width_p`=8, unsigned 5 ÷ 0 → `quotient_o`=0xFF, `remainder_o`=0x05; signed 0x80 ÷ 0xFF → `quotient_o`=0x80, `remainder_o`=0x00. Check `v_o` at t+1 with `BSG_DIV_SEQ_ZERO_FAST_EN` defined and at t+9 without it.
- Backpressure: hold `yumi_i`=0 for 5 cycles after `v_o` rises while toggling `v_i`/operands → `v_o`, `quotient_o`, `remainder_o` stable and `ready_o`=0. `yumi_i` pulse → `ready_o`=1 next cycle.
- Reset at cycle t+4 of a divide → `v_o`=0 and outputs 0 immediately. A new unsigned 100 ÷ 10 after reset deassertion yields 0x0A, 0x00 with normal latency.
- Random sweep of `width_p`=8 signed and unsigned operands against a reference model, with back-to-back accepts using `yumi_i` in the first DONE cycle → every result matches, with exactly `width_p`+2 cycles per operation.

Source files
------------

// File: rtl/bsg_div_seq_if.sv
// Operand/result handshake bundle for bsg_div_seq: ready/valid operands in, valid/yumi results out.
// slave is the divider side; master is the producer/consumer side.
interface bsg_div_seq_if #(
    parameter int width_p = 32
);
    logic               v_i;
    logic               ready_o;
    logic [width_p-1:0] dividend_i;
    logic [width_p-1:0] divisor_i;
    logic               signed_i;
    logic               v_o;
    logic [width_p-1:0] quotient_o;
    logic [width_p-1:0] remainder_o;
    logic               yumi_i;

    modport slave (
        input  v_i, dividend_i, divisor_i, signed_i, yumi_i,
        output ready_o, v_o, quotient_o, remainder_o
    );

    modport master (
        output v_i, dividend_i, divisor_i, signed_i, yumi_i,
        input  ready_o, v_o, quotient_o, remainder_o
    );
endinterface

// File: rtl/bsg_div_seq.sv
// Sequential radix-2 restoring divider (signed/unsigned), one quotient bit per cycle.
// Define BSG_DIV_SEQ_ZERO_FAST_EN to complete a divide-by-zero in one cycle instead of width_p+1.
module bsg_div_seq #(
    parameter int width_p = 32
) (
    input logic           clk_i,
    input logic           reset_i,
    bsg_div_seq_if.slave  io
);
    localparam int cnt_w_lp = $clog2(width_p);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic [width_p-1:0]  dvs_q, dvs_d;
    logic [width_p-1:0]  rem_q, rem_d;
    logic [width_p-1:0]  quo_q, quo_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;
    logic [width_p-1:0]  quotient_q, quotient_d;
    logic [width_p-1:0]  remainder_q, remainder_d;

    logic                ready;
    logic                accept;
    logic                dd_neg, dv_neg;
    logic [width_p-1:0]  dd_mag, dv_mag;
    logic [width_p:0]    rem_sh, diff;
    logic                nonneg;
    logic [width_p-1:0]  rem_nx, quo_nx;

    assign ready  = (state_q == IDLE) & ~reset_i;
    assign accept = io.v_i & ready;

    assign dd_neg = io.signed_i & io.dividend_i[width_p-1];
    assign dv_neg = io.signed_i & io.divisor_i[width_p-1];
    assign dd_mag = dd_neg ? (~io.dividend_i + 1'b1) : io.dividend_i;
    assign dv_mag = dv_neg ? (~io.divisor_i + 1'b1) : io.divisor_i;

    // Partial remainder is < divisor, so the true difference always fits a signed width_p+1 value.
    assign rem_sh = {rem_q, quo_q[width_p-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign nonneg = ~diff[width_p];
    assign rem_nx = nonneg ? diff[width_p-1:0] : rem_sh[width_p-1:0];
    assign quo_nx = {quo_q[width_p-2:0], nonneg};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    dvs_d   = dv_mag;
                    quo_d   = dd_mag;
                    rem_d   = '0;
                    cnt_d   = cnt_w_lp'(width_p - 1);
                    // A zero divisor yields an all-ones magnitude quotient that must stay all ones.
                    qneg_d  = (dd_neg ^ dv_neg) & (io.divisor_i != '0);
                    rneg_d  = dd_neg;
                    state_d = CALC;
`ifdef BSG_DIV_SEQ_ZERO_FAST_EN
                    if (io.divisor_i == '0) begin
                        quotient_d  = '1;
                        remainder_d = io.dividend_i;
                        state_d     = DONE;
                    end
`endif
                end
            end
            CALC: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    quotient_d  = qneg_q ? (~quo_nx + 1'b1) : quo_nx;
                    remainder_d = rneg_q ? (~rem_nx + 1'b1) : rem_nx;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (io.yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            qneg_q      <= qneg_d;
            rneg_q      <= rneg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign io.ready_o     = ready;
    assign io.v_o         = (state_q == DONE);
    assign io.quotient_o  = quotient_q;
    assign io.remainder_o = remainder_q;
endmodule

// File: tb/tb_bsg_div_seq.sv
// Scoreboard bench for bsg_div_seq at width_p=8: directed vectors, latency, backpressure and reset.
// Expected results are pushed on issue and checked by a monitor on each consumed result.
module tb_bsg_div_seq;
    localparam int W = 8;
`ifdef BSG_DIV_SEQ_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_i;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_acc = 0;
    int   last_gap = 0;
    logic [2*W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] dd;
        logic [W-1:0] dv;
        logic         sg;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } vec_t;

    vec_t vecs[$] = '{
        '{8'hC8, 8'h07, 1'b0, 8'h1C, 8'h04},
        '{8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF},
        '{8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01},
        '{8'h05, 8'h00, 1'b0, 8'hFF, 8'h05},
        '{8'h80, 8'hFF, 1'b1, 8'h80, 8'h00},
        '{8'hF9, 8'hFE, 1'b1, 8'h03, 8'hFF},
        '{8'hFF, 8'h01, 1'b0, 8'hFF, 8'h00},
        '{8'hFF, 8'hFF, 1'b1, 8'h01, 8'h00},
        '{8'hFF, 8'hFF, 1'b0, 8'h01, 8'h00},
        '{8'h80, 8'h00, 1'b1, 8'hFF, 8'h80},
        '{8'hFB, 8'h00, 1'b1, 8'hFF, 8'hFB},
        '{8'h0D, 8'hC8, 1'b0, 8'h00, 8'h0D},
        '{8'hC8, 8'h0D, 1'b0, 8'h0F, 8'h05},
        '{8'hC8, 8'h0D, 1'b1, 8'hFC, 8'hFC},
        '{8'h7F, 8'h80, 1'b1, 8'h00, 8'h7F},
        '{8'h80, 8'h02, 1'b1, 8'hC0, 8'h00},
        '{8'h80, 8'h80, 1'b0, 8'h01, 8'h00},
        '{8'h81, 8'h7F, 1'b1, 8'hFF, 8'h00},
        '{8'h00, 8'h05, 1'b1, 8'h00, 8'h00},
        '{8'hF0, 8'h40, 1'b0, 8'h03, 8'h30}
    };

    bsg_div_seq_if #(.width_p(W)) io ();

    bsg_div_seq #(.width_p(W)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .io      (io)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every consumed result is checked against the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [2*W-1:0] e;
        if (!reset_i && io.v_o && io.yumi_i) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("quotient", int'(io.quotient_o), int'(e[2*W-1:W]));
                chk("remainder", int'(io.remainder_o), int'(e[W-1:0]));
            end
        end
    end

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!io.ready_o && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        ok = io.ready_o;
        if (!ok) chk("ready_wait", 0, 1);
    endtask

    task automatic run_op(input vec_t v, input int hold, input bit chk_gap);
        int lat;
        int exp_lat;
        bit ok;
        exp_lat = (FAST && v.dv == '0) ? 0 : W;
        wait_ready(ok);
        if (!ok) return;
        io.v_i        = 1'b1;
        io.dividend_i = v.dd;
        io.divisor_i  = v.dv;
        io.signed_i   = v.sg;
        exp_q.push_back({v.q, v.r});
        @(posedge clk); #1;
        if (chk_gap) chk("accept_period", cyc - last_acc, last_gap);
        last_acc      = cyc;
        last_gap      = exp_lat + 2;
        io.v_i        = 1'b0;
        io.dividend_i = W'($urandom);
        io.divisor_i  = W'($urandom);
        io.signed_i   = 1'($urandom);
        lat = 0;
        while (!io.v_o && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat);
        if (!io.v_o) return;
        for (int i = 0; i < hold; i++) begin
            io.v_i        = 1'($urandom);
            io.dividend_i = W'($urandom);
            io.divisor_i  = W'($urandom);
            io.signed_i   = 1'($urandom);
            @(posedge clk); #1;
            chk("hold_v_o", int'(io.v_o), 1);
            chk("hold_quotient", int'(io.quotient_o), int'(v.q));
            chk("hold_remainder", int'(io.remainder_o), int'(v.r));
            chk("hold_ready", int'(io.ready_o), 0);
        end
        io.v_i    = 1'b0;
        io.yumi_i = 1'b1;
        @(posedge clk); #1;
        io.yumi_i = 1'b0;
        chk("ready_after_yumi", int'(io.ready_o), 1);
        chk("v_o_after_yumi", int'(io.v_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bit ok;
        reset_i       = 1'b1;
        io.v_i        = 1'b0;
        io.dividend_i = '0;
        io.divisor_i  = '0;
        io.signed_i   = 1'b0;
        io.yumi_i     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_v_o", int'(io.v_o), 0);
        chk("rst_quotient", int'(io.quotient_o), 0);
        chk("rst_remainder", int'(io.remainder_o), 0);
        chk("rst_ready", int'(io.ready_o), 0);
        reset_i = 1'b0;
        #1;
        chk("ready_after_rst", int'(io.ready_o), 1);
        @(posedge clk); #1;

        // 200/7 with 5 cycles of backpressure, then a few directed cases
        run_op(vecs[0], 5, 1'b0);
        for (int i = 1; i < 5; i++) run_op(vecs[i], 0, 1'b0);

        // Reset in cycle t+4 of an in-flight divide: no result may emerge
        wait_ready(ok);
        io.v_i        = 1'b1;
        io.dividend_i = 8'hC8;
        io.divisor_i  = 8'h07;
        io.signed_i   = 1'b0;
        @(posedge clk); #1;
        io.v_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b1;
        #1;
        chk("midrst_v_o", int'(io.v_o), 0);
        chk("midrst_quotient", int'(io.quotient_o), 0);
        chk("midrst_remainder", int'(io.remainder_o), 0);
        chk("midrst_ready", int'(io.ready_o), 0);
        @(posedge clk); #1;
        reset_i = 1'b0;
        #1;
        chk("ready_after_midrst", int'(io.ready_o), 1);
        run_op('{8'h64, 8'h0A, 1'b0, 8'h0A, 8'h00}, 0, 1'b0);

        // Back-to-back over the whole table, consuming in the first DONE cycle
        for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], 0, i != 0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
